// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, instruction-class enum and field widths
// for the MIPS decode pipeline.
package decode_pkg;

   localparam int INS_W   = 32;
   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNC_W  = 6;
   localparam int IMM16_W = 16;
   localparam int TGT_W   = 26;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;

   typedef enum logic [1:0] {
      CLS_R = 2'd0,
      CLS_I = 2'd1,
      CLS_J = 2'd2
   } cls_t;

endpackage

// File: rtl/decode_fields.sv
// decode_fields: purely combinational split of one 32-bit MIPS instruction
// into its fields, extended immediate and instruction class.
module decode_fields
   import decode_pkg::*;
#(
   parameter int IMM_W = 32
) (
   input  logic [INS_W-1:0]   ins,
   output logic [OP_W-1:0]    op,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [REG_W-1:0]   rd,
   output logic [SHAMT_W-1:0] shamt,
   output logic [FUNC_W-1:0]  func,
   output logic [TGT_W-1:0]   target,
   output logic [IMM_W-1:0]   imm,
   output cls_t               cls
);

   // Logical immediates zero-extend, LUI places imm16 in the upper half,
   // everything else sign-extends; built at 64 bits then cut to IMM_W so
   // IMM_W = 16 needs no zero-width replication.
   function automatic logic [IMM_W-1:0] ext_imm(input logic [OP_W-1:0] opc,
                                                input logic [IMM16_W-1:0] i16);
      logic [63:0] wide;
      case (opc)
         OP_ANDI, OP_ORI, OP_XORI: wide = {48'h0, i16};
         OP_LUI:                   wide = {{32{i16[15]}}, i16, 16'h0};
         default:                  wide = {{48{i16[15]}}, i16};
      endcase
      return wide[IMM_W-1:0];
   endfunction

   assign op     = ins[31:26];
   assign rs     = ins[25:21];
   assign rt     = ins[20:16];
   assign rd     = ins[15:11];
   assign shamt  = ins[10:6];
   assign func   = ins[5:0];
   assign target = ins[25:0];
   assign imm    = ext_imm(ins[31:26], ins[15:0]);

   // Class from opcode: R-type, the two jumps, everything else immediate.
   always_comb begin
      cls = CLS_I;
      case (ins[31:26])
         OP_RTYPE:     cls = CLS_R;
         OP_J, OP_JAL: cls = CLS_J;
         default:      cls = CLS_I;
      endcase
   end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: DEPTH-entry instruction buffer with ready/valid on both sides,
// decoding the head entry combinationally. Optional statistics counters
// (stat_dec, stat_stall) are built when DECODE_PIPE_STATS_EN is defined.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int IMM_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INS_W-1:0]   in_ins,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [OP_W-1:0]    out_op,
   output logic [REG_W-1:0]   out_rs,
   output logic [REG_W-1:0]   out_rt,
   output logic [REG_W-1:0]   out_rd,
   output logic [SHAMT_W-1:0] out_shamt,
   output logic [FUNC_W-1:0]  out_func,
   output logic [TGT_W-1:0]   out_target,
   output logic [IMM_W-1:0]   out_imm,
   output logic [1:0]         out_cls
`ifdef DECODE_PIPE_STATS_EN
   ,
   output logic [31:0]        stat_dec,
   output logic [31:0]        stat_stall
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("decode_pipe: DEPTH must be a power of two in 2..8");
   end
   if (XLEN < 32 || XLEN > 64) begin : g_bad_xlen
      $error("decode_pipe: XLEN must be in 32..64");
   end
   if (IMM_W < 16 || IMM_W > 64) begin : g_bad_immw
      $error("decode_pipe: IMM_W must be in 16..64");
   end

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_t;

   occ_t               state, state_nxt;
   logic [CW-1:0]      count, count_nxt;
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [INS_W-1:0]   ins_mem [DEPTH];
   logic [XLEN-1:0]    pc_mem  [DEPTH];
   logic               push, pop;

   logic [OP_W-1:0]    h_op;
   logic [REG_W-1:0]   h_rs, h_rt, h_rd;
   logic [SHAMT_W-1:0] h_shamt;
   logic [FUNC_W-1:0]  h_func;
   logic [TGT_W-1:0]   h_target;
   logic [IMM_W-1:0]   h_imm;
   cls_t               h_cls;

   // Full buffer refuses input even if the head is being consumed (no pass-through).
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // Occupancy and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Next occupancy state; flush overrides any push or pop in the same cycle.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      if (flush) begin
         state_nxt = ST_EMPTY;
         count_nxt = '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state_nxt = ST_PARTIAL;
                  count_nxt = CW'(1);
               end
            end
            ST_PARTIAL: begin
               if (push && !pop) begin
                  count_nxt = count + CW'(1);
                  if (count == CW'(DEPTH - 1)) state_nxt = ST_FULL;
               end else if (pop && !push) begin
                  count_nxt = count - CW'(1);
                  if (count == CW'(1)) state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_nxt = ST_PARTIAL;
                  count_nxt = count - CW'(1);
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               count_nxt = '0;
            end
         endcase
      end
   end

   // Payload storage is written on push only and carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         ins_mem[wr_ptr] <= in_ins;
         pc_mem[wr_ptr]  <= in_pc;
      end
   end

   decode_fields #(.IMM_W(IMM_W)) u_fields (
      .ins    (ins_mem[rd_ptr]),
      .op     (h_op),
      .rs     (h_rs),
      .rt     (h_rt),
      .rd     (h_rd),
      .shamt  (h_shamt),
      .func   (h_func),
      .target (h_target),
      .imm    (h_imm),
      .cls    (h_cls)
   );

   // Head fields are forced to zero whenever nothing valid is presented.
   always_comb begin
      out_pc     = '0;
      out_op     = '0;
      out_rs     = '0;
      out_rt     = '0;
      out_rd     = '0;
      out_shamt  = '0;
      out_func   = '0;
      out_target = '0;
      out_imm    = '0;
      out_cls    = '0;
      if (out_valid) begin
         out_pc     = pc_mem[rd_ptr];
         out_op     = h_op;
         out_rs     = h_rs;
         out_rt     = h_rt;
         out_rd     = h_rd;
         out_shamt  = h_shamt;
         out_func   = h_func;
         out_target = h_target;
         out_imm    = h_imm;
         out_cls    = h_cls;
      end
   end

`ifdef DECODE_PIPE_STATS_EN
   // Pop and stall counters; wrap freely and survive flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_dec   <= '0;
         stat_stall <= '0;
      end else begin
         if (pop) stat_dec <= stat_dec + 32'd1;
         if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
